// File: rtl/pa_fpu.sv
// Shared FPU types and constants: result-stage FSM states and IEEE-754 single constants.
package pa_fpu;

  typedef enum logic [2:0] {
    norm_idle_st,
    norm_check_st,
    norm_shift_st,
    norm_round_st,
    norm_done_st
  } e_norm_state;

  localparam int unsigned FP_BIAS    = 127;
  localparam int unsigned FP_EXP_MAX = 255;
  localparam logic [31:0] FP_QNAN    = 32'h7FC0_0000;

endpackage

// File: rtl/fpu_lzc.sv
// Parameterised leading-zero counter; an all-zero input returns W.
module fpu_lzc #(
  parameter int unsigned W     = 48,
  parameter int unsigned CNT_W = $clog2(W + 1)
) (
  input  logic [W-1:0]     data_i,
  output logic [CNT_W-1:0] cnt_o
);

  always_comb begin
    cnt_o = CNT_W'(W);
    // Ascending scan: the highest set bit is written last and wins.
    for (int unsigned i = 0; i < W; i++) begin
      if (data_i[i]) cnt_o = CNT_W'(W - 1 - i);
    end
  end

endmodule

// File: rtl/fpu_norm_round.sv
// FPU result stage: normalise, round-to-nearest-even, pack to IEEE-754 single.
// Define FPU_NORM_FAST_EN for a single-cycle normalising shift instead of one bit per cycle.
module fpu_norm_round
  import pa_fpu::*;
#(
  parameter int unsigned MANT_W = 48,
  parameter int unsigned EXP_W  = 10
) (
  input  logic              clk,
  input  logic              arst,
  input  logic              start,
  input  logic              in_sign,
  input  logic [EXP_W-1:0]  in_exp,
  input  logic [MANT_W-1:0] in_mant,
  input  logic              in_sticky,
  input  logic              in_nan,
  output logic              busy,
  output logic              done,
  output logic [31:0]       result,
  output logic              flag_ovf,
  output logic              flag_unf,
  output logic              flag_inx
);

  localparam logic signed [EXP_W-1:0] EXP_MAX  = EXP_W'(FP_EXP_MAX);
  localparam logic signed [EXP_W-1:0] EXP_ZERO = '0;
  localparam logic signed [EXP_W-1:0] EXP_ONE  = EXP_W'(1);

  e_norm_state              state_q, state_d;
  logic                     sign_q, sign_d;
  logic signed [EXP_W-1:0]  exp_q, exp_d;
  logic [MANT_W-1:0]        mant_q, mant_d;
  logic                     sticky_q, sticky_d;
  logic                     nan_q, nan_d;
  logic [31:0]              result_q, result_d;
  logic                     ovf_q, ovf_d;
  logic                     unf_q, unf_d;
  logic                     inx_q, inx_d;

  logic [22:0]              frac;
  logic                     guard, rnd, stk, round_up;
  logic [23:0]              frac_sum;
  logic signed [EXP_W-1:0]  exp_rnd;

  assign frac     = mant_q[MANT_W-2 -: 23];
  assign guard    = mant_q[MANT_W-25];
  assign rnd      = mant_q[MANT_W-26];
  assign stk      = (|mant_q[MANT_W-27:0]) | sticky_q;
  assign round_up = guard & (rnd | stk | frac[0]);
  assign frac_sum = {1'b0, frac} + {23'b0, round_up};
  // A carry out of the fraction leaves frac_sum[22:0] at zero and bumps the exponent.
  assign exp_rnd  = exp_q + EXP_W'(frac_sum[23]);

`ifdef FPU_NORM_FAST_EN
  localparam int unsigned LZC_W = $clog2(MANT_W + 1);
  logic [LZC_W-1:0] lzc;

  fpu_lzc #(
    .W     (MANT_W),
    .CNT_W (LZC_W)
  ) u_lzc (
    .data_i (mant_q),
    .cnt_o  (lzc)
  );
`endif

  always_comb begin
    state_d  = state_q;
    sign_d   = sign_q;
    exp_d    = exp_q;
    mant_d   = mant_q;
    sticky_d = sticky_q;
    nan_d    = nan_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    inx_d    = inx_q;

    unique case (state_q)
      norm_idle_st: begin
        if (start) begin
          sign_d   = in_sign;
          exp_d    = in_exp;
          mant_d   = in_mant;
          sticky_d = in_sticky;
          nan_d    = in_nan;
          ovf_d    = 1'b0;
          unf_d    = 1'b0;
          inx_d    = 1'b0;
          state_d  = norm_check_st;
        end
      end
      norm_check_st: begin
        if (nan_q) begin
          result_d = FP_QNAN;
          state_d  = norm_done_st;
        end else if (mant_q == '0) begin
          result_d = {sign_q, 31'b0};
          state_d  = norm_done_st;
        end else begin
`ifdef FPU_NORM_FAST_EN
          mant_d  = mant_q << lzc;
          exp_d   = exp_q - EXP_W'(lzc);
          state_d = norm_round_st;
`else
          state_d = mant_q[MANT_W-1] ? norm_round_st : norm_shift_st;
`endif
        end
      end
      norm_shift_st: begin
        mant_d = mant_q << 1;
        exp_d  = exp_q - EXP_ONE;
        if (mant_q[MANT_W-2]) state_d = norm_round_st;
      end
      norm_round_st: begin
        if (exp_rnd >= EXP_MAX) begin
          result_d = {sign_q, 8'hFF, 23'b0};
          ovf_d    = 1'b1;
          inx_d    = 1'b1;
        end else if (exp_rnd <= EXP_ZERO) begin
          result_d = {sign_q, 31'b0};
          unf_d    = 1'b1;
          inx_d    = 1'b1;
        end else begin
          result_d = {sign_q, exp_rnd[7:0], frac_sum[22:0]};
          inx_d    = guard | rnd | stk;
        end
        state_d = norm_done_st;
      end
      norm_done_st: state_d = norm_idle_st;
      default:      state_d = norm_idle_st;
    endcase
  end

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      state_q  <= norm_idle_st;
      sign_q   <= 1'b0;
      exp_q    <= '0;
      mant_q   <= '0;
      sticky_q <= 1'b0;
      nan_q    <= 1'b0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      inx_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sign_q   <= sign_d;
      exp_q    <= exp_d;
      mant_q   <= mant_d;
      sticky_q <= sticky_d;
      nan_q    <= nan_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      inx_q    <= inx_d;
    end
  end

  assign busy     = (state_q != norm_idle_st);
  assign done     = (state_q == norm_done_st);
  assign result   = result_q;
  assign flag_ovf = ovf_q;
  assign flag_unf = unf_q;
  assign flag_inx = inx_q;

endmodule

// File: tb/tb_fpu_norm_round.sv
// Self-checking bench for fpu_norm_round: vector table driven through a scoreboard queue,
// plus hand sequences for start-while-busy, result hold and mid-shift reset.
module tb_fpu_norm_round;

  logic        clk;
  logic        arst;
  logic        start;
  logic        in_sign;
  logic [9:0]  in_exp;
  logic [47:0] in_mant;
  logic        in_sticky;
  logic        in_nan;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        flag_ovf;
  logic        flag_unf;
  logic        flag_inx;

  fpu_norm_round #(
    .MANT_W (48),
    .EXP_W  (10)
  ) dut (
    .clk       (clk),
    .arst      (arst),
    .start     (start),
    .in_sign   (in_sign),
    .in_exp    (in_exp),
    .in_mant   (in_mant),
    .in_sticky (in_sticky),
    .in_nan    (in_nan),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .flag_ovf  (flag_ovf),
    .flag_unf  (flag_unf),
    .flag_inx  (flag_inx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        s;
    logic [9:0]  e;
    logic [47:0] m;
    logic        stk;
    logic        nan;
    logic [31:0] res;
    logic [2:0]  flg;  // {ovf, unf, inx}
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic [2:0]  flg;
    int          lat;
  } exp_t;

  localparam int NVEC = 14;
  vec_t vecs[NVEC];
  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, req);
  endtask

  function automatic int lead_zeros(input logic [47:0] m);
    int n = 0;
    for (int i = 47; i >= 0; i--) begin
      if (m[i]) break;
      n++;
    end
    return n;
  endfunction

  function automatic int exp_latency(input vec_t v);
    if (v.nan || v.m == '0) return 2;
`ifdef FPU_NORM_FAST_EN
    return 3;
`else
    return 3 + lead_zeros(v.m);
`endif
  endfunction

  // Drive one operation, optionally re-pulse start while busy, and compare against the queue.
  task automatic run_vec(input vec_t v, input bit inject, input string tag);
    exp_t e;
    exp_t got_e;
    int   lat;
    bit   got;
    e.res = v.res;
    e.flg = v.flg;
    e.lat = exp_latency(v);
    @(negedge clk);
    in_sign   = v.s;
    in_exp    = v.e;
    in_mant   = v.m;
    in_sticky = v.stk;
    in_nan    = v.nan;
    start     = 1'b1;
    sb_q.push_back(e);
    @(posedge clk);
    #1 start = 1'b0;
    got = 1'b0;
    lat = 0;
    for (int c = 1; c <= 200 && !got; c++) begin
      @(negedge clk);
      if (c == 1) chk({tag, "_flags_clr"}, {29'b0, flag_ovf, flag_unf, flag_inx}, 32'd0);
      if (inject && c == 1) begin
        start   = 1'b1;
        in_nan  = 1'b1;
        in_mant = 48'h0;
      end
      if (inject && c == 2) begin
        start  = 1'b0;
        in_nan = 1'b0;
      end
      if (done) begin
        got = 1'b1;
        lat = c;
      end
    end
    got_e = sb_q.pop_front();
    if (!got) begin
      n_checks++;
      $display("FAIL %s_timeout: done not seen within 200 cycles, expected at cycle %0d",
               tag, got_e.lat);
    end else begin
      chk({tag, "_result"}, result, got_e.res);
      chk({tag, "_flags"}, {29'b0, flag_ovf, flag_unf, flag_inx}, {29'b0, got_e.flg});
      chk({tag, "_latency"}, 32'(lat), 32'(got_e.lat));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit saw_done;
    vecs[0]  = '{1'b0, 10'd127, 48'h8000_0000_0000, 1'b0, 1'b0, 32'h3F80_0000, 3'b000};
    vecs[1]  = '{1'b0, 10'd128, 48'h4000_0000_0000, 1'b0, 1'b0, 32'h3F80_0000, 3'b000};
    vecs[2]  = '{1'b0, 10'd127, 48'h8000_0080_0000, 1'b0, 1'b0, 32'h3F80_0000, 3'b001};
    vecs[3]  = '{1'b0, 10'd127, 48'h8000_0180_0000, 1'b0, 1'b0, 32'h3F80_0002, 3'b001};
    vecs[4]  = '{1'b0, 10'd127, 48'hFFFF_FF80_0000, 1'b0, 1'b0, 32'h4000_0000, 3'b001};
    vecs[5]  = '{1'b1, 10'd255, 48'h8000_0000_0000, 1'b0, 1'b0, 32'hFF80_0000, 3'b101};
    vecs[6]  = '{1'b0, 10'd1,   48'h4000_0000_0000, 1'b0, 1'b0, 32'h0000_0000, 3'b011};
    vecs[7]  = '{1'b1, 10'd127, 48'h0,              1'b0, 1'b0, 32'h8000_0000, 3'b000};
    vecs[8]  = '{1'b0, 10'd127, 48'h8000_0000_0000, 1'b0, 1'b1, 32'h7FC0_0000, 3'b000};
    vecs[9]  = '{1'b0, 10'd127, 48'h8000_0000_0000, 1'b1, 1'b0, 32'h3F80_0000, 3'b001};
    vecs[10] = '{1'b0, 10'd174, 48'h0000_0000_0001, 1'b0, 1'b0, 32'h3F80_0000, 3'b000};
    vecs[11] = '{1'b0, 10'h3FB, 48'h8000_0000_0000, 1'b0, 1'b0, 32'h0000_0000, 3'b011};
    vecs[12] = '{1'b0, 10'd127, 48'h8000_00C0_0000, 1'b0, 1'b0, 32'h3F80_0001, 3'b001};
    vecs[13] = '{1'b0, 10'd254, 48'hFFFF_FF80_0000, 1'b0, 1'b0, 32'h7F80_0000, 3'b101};

    arst      = 1'b0;
    start     = 1'b0;
    in_sign   = 1'b0;
    in_exp    = '0;
    in_mant   = '0;
    in_sticky = 1'b0;
    in_nan    = 1'b0;
    #12;
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_flags", {29'b0, flag_ovf, flag_unf, flag_inx}, 32'd0);
    @(negedge clk);
    arst = 1'b1;

    for (int i = 0; i < NVEC; i++) run_vec(vecs[i], 1'b0, $sformatf("vec%0d", i));

    // Start re-pulsed (as a NaN request) while busy must be ignored.
    run_vec(vecs[1], 1'b1, "busy_start");
    repeat (3) @(negedge clk);
    chk("busy_start_idle", {31'b0, busy}, 32'd0);
    chk("hold_result", result, 32'h3F80_0000);

    // Reset asserted while the deep-shift operation is in flight.
    @(negedge clk);
    in_sign = 1'b0;
    in_exp  = 10'd174;
    in_mant = 48'h1;
    in_nan  = 1'b0;
    start   = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(negedge clk);
    arst = 1'b0;
    #1;
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_done", {31'b0, done}, 32'd0);
    chk("abort_result", result, 32'd0);
    chk("abort_flags", {29'b0, flag_ovf, flag_unf, flag_inx}, 32'd0);
    saw_done = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    arst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    chk("abort_no_done", {31'b0, saw_done}, 32'd0);
    run_vec(vecs[3], 1'b0, "after_abort");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fpu_norm_round.md
Name: fpu_norm_round

Overview:
- Downstream result stage of the FPU sequencer. Consumes the raw sign/exponent/wide mantissa produced by the add/sub/mul/div datapath and turns it into a packed IEEE-754 single.
- Processing: normalises by shifting, rounds to nearest-even, then detects zero, overflow and underflow.
- The sequencer pulses start when it reaches result_valid_st and waits for done before returning to idle_st.

Parameters:
- MANT_W, 48, raw mantissa width; leading-one target is bit MANT_W-1 (min 27).
- EXP_W, 10, signed two's-complement raw exponent width; bias 127.

Ports:
- clk  in  1  system clock
- arst  in  1  asynchronous reset, active-low
- start  in  1  one-cycle request; sampled only in IDLE
- in_sign  in  1  result sign
- in_exp  in  EXP_W  raw exponent; value = in_mant/2^(MANT_W-1) * 2^(in_exp-127)
- in_mant  in  MANT_W  raw unsigned mantissa
- in_sticky  in  1  OR of bits already discarded upstream
- in_nan  in  1  force quiet NaN result
- busy  out  1  high in every non-IDLE state
- done  out  1  one-cycle pulse; result/flags valid
- result  out  32  packed single
- flag_ovf  out  1  overflow occurred
- flag_unf  out  1  underflow occurred (flushed to zero)
- flag_inx  out  1  result inexact

Behaviour:
- Reset:
  - All outputs 0; state IDLE.
  - Reset mid-operation aborts immediately with no done pulse.
- Start in IDLE:
  - Registers all inputs; goes to CHECK.
  - start is ignored while busy.
- CHECK:
  - in_nan: result=0x7FC00000, flags 0, go DONE.
  - mant==0: result={sign,31'b0}, flags 0, go DONE.
  - mant[MANT_W-1]==1: go ROUND; else go SHIFT.
- SHIFT:
  - Each cycle: mant<<=1, exp-=1.
  - Go ROUND when the shifted mant's MSB is 1; at most MANT_W-1 cycles.
  - exp may go negative; no saturation.
- ROUND:
  - Fields: frac=mant[MANT_W-2 -: 23], guard=next bit, round=next bit, sticky=OR(remaining bits)|in_sticky.
  - Round up iff guard & (round|sticky|frac[0]).
  - Carry-out of frac (all ones +1): frac=0, exp+=1.
  - Priority:
    - exp>=255: result={sign,0xFF,0}, flag_ovf=1, flag_inx=1.
    - exp<=0: result={sign,31'b0}, flag_unf=1, flag_inx=1. Subnormals are not produced.
    - Otherwise: result={sign,exp[7:0],frac}, flag_inx=guard|round|sticky.
  - Go DONE.
- DONE: done=1 for exactly this cycle, then IDLE.
- Holding: result and flags hold until the next accepted start, which clears the flags.
- Latency: start cycle = 0; done high in cycle 3+k, where k = left-shift count. NaN/zero: done in cycle 2.
- Width rule: exp arithmetic is EXP_W-bit signed; comparisons are signed.

Optional Feature:
- Macro: FPU_NORM_FAST_EN.
- Defined: SHIFT state is removed. CHECK computes the leading-zero count of mant (priority encoder) and applies the full shift and exp-=lzc in one cycle, then goes to ROUND. Latency is a fixed 3 cycles (2 for NaN/zero).
- Undefined: one-bit-per-cycle SHIFT as above.
- Results and flags are bit-identical in both builds.

Decomposition:
- Add to pa_fpu:
  - enum e_norm_state {norm_idle_st, norm_check_st, norm_shift_st, norm_round_st, norm_done_st}.
  - Constants FP_BIAS=127, FP_EXP_MAX=255, FP_QNAN=32'h7FC00000.
- Sub-module fpu_lzc (parameterised leading-zero counter), instantiated only under FPU_NORM_FAST_EN.

Test Plan:
- sign=0, exp=127, mant=0x800000000000 -> result 0x3F800000, flags 0, done in cycle 3. Same with exp=128, mant=0x400000000000 -> 0x3F800000, cycle 4 (cycle 3 with FAST).
- mant=0x800000800000, exp=127 -> 0x3F800000, inx=1 (tie to even). mant=0x800001800000 -> 0x3F800002, inx=1.
- mant=0xFFFFFF800000, exp=127 -> carry-out, 0x40000000, inx=1.
- exp=255, mant=0x800000000000, sign=1 -> 0xFF800000, ovf=1. exp=1, mant=0x400000000000 -> 0x00000000, unf=1.
- mant=0, sign=1 -> 0x80000000 in cycle 2. in_nan=1 -> 0x7FC00000. start pulsed while busy -> ignored, first result unchanged.
- arst low during SHIFT -> all outputs 0, no done; a following start completes normally.
